// File: rtl/bcd_sum_display.sv
// Two-sum BCD display driver for a four-digit, multiplexed, common-anode
// seven-segment module. The right pair of digits shows the newest captured
// sum (tens, ones) and the left pair shows the one before it, with the
// decimal point marking the boundary between the two.
module bcd_sum_display #(
  parameter int unsigned REFRESH_DIV   = 50000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] bcd_in,
  input  logic       carry_in,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic       disp_valid,
  output logic       err
);

  localparam logic [15:0] TERMINAL = 16'(REFRESH_DIV - 1);

  logic [15:0] refresh_cnt;
  logic [1:0]  sel;
  logic [3:0]  cur_ones;
  logic        cur_tens;
  logic [3:0]  prev_ones;
  logic        prev_tens;
  logic        cur_valid;
  logic        prev_valid;
  logic        at_terminal;
  logic [3:0]  digit;
  logic        blank;
  logic        dp_on;
  logic [6:0]  pattern;

  assign at_terminal = (refresh_cnt == TERMINAL);

  // Scan timer: each digit stays enabled for REFRESH_DIV cycles, and the digit select steps on the wrapping edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= 16'd0;
      sel         <= 2'd0;
    end else if (at_terminal) begin
      refresh_cnt <= 16'd0;
      sel         <= sel + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 16'd1;
    end
  end

  // Sum history: every load shifts the current sum into the previous slot, and an out-of-range ones digit latches err.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_ones   <= 4'd0;
      cur_tens   <= 1'b0;
      prev_ones  <= 4'd0;
      prev_tens  <= 1'b0;
      cur_valid  <= 1'b0;
      prev_valid <= 1'b0;
      err        <= 1'b0;
    end else if (load) begin
      cur_ones   <= bcd_in;
      cur_tens   <= carry_in;
      prev_ones  <= cur_ones;
      prev_tens  <= cur_tens;
      prev_valid <= cur_valid;
      cur_valid  <= 1'b1;
      if (bcd_in > 4'd9) begin
        err <= 1'b1;
      end
    end
  end

  // Pick the digit for the enabled position and decide whether it is blanked or carries the decimal point.
  always_comb begin
    digit = 4'd0;
    blank = 1'b0;
    dp_on = 1'b0;
    case (sel)
      2'd0: begin
        digit = cur_ones;
        blank = !cur_valid;
      end
      2'd1: begin
        digit = {3'b000, cur_tens};
        blank = !cur_valid || (BLANK_LEADING && !cur_tens);
      end
      2'd2: begin
        digit = prev_ones;
        blank = !prev_valid;
        dp_on = prev_valid;
      end
      default: begin
        digit = {3'b000, prev_tens};
        blank = !prev_valid || (BLANK_LEADING && !prev_tens);
      end
    endcase
  end

  // Active-low segment patterns g..a; anything above 9 is shown as 'E' so a bad upstream digit is visible.
  always_comb begin
    pattern = 7'h06;
    case (digit)
      4'd0:    pattern = 7'h40;
      4'd1:    pattern = 7'h79;
      4'd2:    pattern = 7'h24;
      4'd3:    pattern = 7'h30;
      4'd4:    pattern = 7'h19;
      4'd5:    pattern = 7'h12;
      4'd6:    pattern = 7'h02;
      4'd7:    pattern = 7'h78;
      4'd8:    pattern = 7'h00;
      4'd9:    pattern = 7'h10;
      default: pattern = 7'h06;
    endcase
  end

  // Drive the panel purely from registered state so the digit enables and segments never glitch on input changes.
  always_comb begin
    an         = ~(4'b0001 << sel);
    seg        = blank ? 8'hFF : {!dp_on, pattern};
    disp_valid = cur_valid;
  end

endmodule

// File: tb/tb_bcd_sum_display.sv
// Scoreboard bench for bcd_sum_display with a four-cycle refresh period.
// Stimulus pushes hand-computed expectations into a queue; the monitor pops
// one entry on each falling edge and compares it against both instances
// (leading-zero blanking on and off).
module tb_bcd_sum_display;

  typedef struct {
    string      name;
    logic [3:0] an;
    logic [7:0] seg;
    logic       dv;
    logic       err;
    bit         chk2;
    logic [7:0] seg2;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       load;
  logic [3:0] bcd_in;
  logic       carry_in;
  logic [7:0] seg;
  logic [3:0] an;
  logic       disp_valid;
  logic       err;
  logic [7:0] seg2;
  logic [3:0] an2;
  logic       disp_valid2;
  logic       err2;

  exp_t scoreboard[$];
  int   assertCount = 0;
  int   failCount   = 0;
  int   mcnt        = 0;
  int   msel        = 0;

  bcd_sum_display #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in), .carry_in(carry_in),
    .seg(seg), .an(an), .disp_valid(disp_valid), .err(err)
  );

  bcd_sum_display #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) dut2 (
    .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in), .carry_in(carry_in),
    .seg(seg2), .an(an2), .disp_valid(disp_valid2), .err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge; the bench tracks scan position on its own (4 cycles per digit, reset restarts it).
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      mcnt = 0;
      msel = 0;
    end else if (mcnt == 3) begin
      mcnt = 0;
      msel = (msel + 1) % 4;
    end else begin
      mcnt = mcnt + 1;
    end
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] b, input logic c);
    load     = 1'b1;
    bcd_in   = b;
    carry_in = c;
    tick();
    load     = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] expAn, input logic [7:0] expSeg,
                             input logic expDv, input logic expErr, input bit chk2, input logic [7:0] expSeg2);
    exp_t e;
    e.name = name;
    e.an   = expAn;
    e.seg  = expSeg;
    e.dv   = expDv;
    e.err  = expErr;
    e.chk2 = chk2;
    e.seg2 = expSeg2;
    scoreboard.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic goToPhase(input int s, input int c);
    int n = 0;
    while (!(msel == s && mcnt == c) && n < 40) begin
      tick();
      n++;
    end
    if (!(msel == s && mcnt == c)) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL goToPhase: got sel %0d cnt %0d, expected sel %0d cnt %0d", msel, mcnt, s, c);
    end
  endtask

  task automatic compareField(input string name, input string field, input logic [7:0] act, input logic [7:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s.%s: got %h, expected %h", name, field, act, exp);
    end
  endtask

  // Monitor: consume one expectation per falling edge and compare against the live outputs.
  always @(negedge clk) begin
    exp_t e;
    if (scoreboard.size() > 0) begin
      e = scoreboard.pop_front();
      compareField(e.name, "an", {4'b0000, an}, {4'b0000, e.an});
      compareField(e.name, "seg", seg, e.seg);
      compareField(e.name, "disp_valid", {7'd0, disp_valid}, {7'd0, e.dv});
      compareField(e.name, "err", {7'd0, err}, {7'd0, e.err});
      if (e.chk2) begin
        compareField(e.name, "an2", {4'b0000, an2}, {4'b0000, e.an});
        compareField(e.name, "seg2", seg2, e.seg2);
        compareField(e.name, "disp_valid2", {7'd0, disp_valid2}, {7'd0, e.dv});
        compareField(e.name, "err2", {7'd0, err2}, {7'd0, e.err});
      end
    end
  end

  initial begin
    rst      = 1'b1;
    load     = 1'b0;
    bcd_in   = 4'd0;
    carry_in = 1'b0;

    // Reset held two cycles, then the scan cadence
    tick();
    tick();
    checkOutput("reset", 4'b1110, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF);
    rst = 1'b0;
    tick(); tick(); tick();
    checkOutput("scan_hold", 4'b1110, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF);
    tick();
    checkOutput("scan_sel1", 4'b1101, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF);
    repeat (4) tick();
    checkOutput("scan_sel2", 4'b1011, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF);
    repeat (4) tick();
    checkOutput("scan_sel3", 4'b0111, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF);
    repeat (4) tick();
    checkOutput("scan_wrap", 4'b1110, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF);

    // Single sum 17
    applyStimulus(4'd7, 1'b1);
    checkOutput("single_sel0", 4'b1110, 8'hF8, 1'b1, 1'b0, 1'b1, 8'hF8);
    goToPhase(1, 0);
    checkOutput("single_sel1", 4'b1101, 8'hF9, 1'b1, 1'b0, 1'b1, 8'hF9);
    goToPhase(2, 0);
    checkOutput("single_sel2", 4'b1011, 8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF);
    goToPhase(3, 0);
    checkOutput("single_sel3", 4'b0111, 8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF);

    // History: 17 then 03 on back-to-back cycles
    applyStimulus(4'd7, 1'b1);
    applyStimulus(4'd3, 1'b0);
    goToPhase(0, 0);
    checkOutput("hist_sel0", 4'b1110, 8'hB0, 1'b1, 1'b0, 1'b1, 8'hB0);
    goToPhase(1, 0);
    checkOutput("hist_sel1", 4'b1101, 8'hFF, 1'b1, 1'b0, 1'b1, 8'hC0);
    goToPhase(2, 0);
    checkOutput("hist_sel2", 4'b1011, 8'h78, 1'b1, 1'b0, 1'b1, 8'h78);
    goToPhase(3, 0);
    checkOutput("hist_sel3", 4'b0111, 8'hF9, 1'b1, 1'b0, 1'b1, 8'hF9);

    // Invalid digit and sticky err
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("err_reset", 4'b1110, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF);
    applyStimulus(4'd12, 1'b0);
    checkOutput("err_sel0", 4'b1110, 8'h86, 1'b1, 1'b1, 1'b1, 8'h86);
    goToPhase(1, 0);
    checkOutput("err_sel1", 4'b1101, 8'hFF, 1'b1, 1'b1, 1'b1, 8'hC0);
    applyStimulus(4'd5, 1'b0);
    goToPhase(0, 0);
    checkOutput("err_sticky", 4'b1110, 8'h92, 1'b1, 1'b1, 1'b1, 8'h92);
    goToPhase(2, 0);
    checkOutput("err_prev_dp", 4'b1011, 8'h06, 1'b1, 1'b1, 1'b1, 8'h06);

    // Load on the terminal-count edge
    goToPhase(3, 3);
    applyStimulus(4'd4, 1'b0);
    checkOutput("tc_load", 4'b1110, 8'h99, 1'b1, 1'b1, 1'b1, 8'h99);

    // Reset wins over a coincident load
    rst      = 1'b1;
    load     = 1'b1;
    bcd_in   = 4'd8;
    carry_in = 1'b1;
    tick();
    rst  = 1'b0;
    load = 1'b0;
    checkOutput("rst_load", 4'b1110, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF);
    goToPhase(2, 0);
    checkOutput("rst_load_prev", 4'b1011, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF);

    // Mid-scan reset with two sums stored
    applyStimulus(4'd2, 1'b1);
    applyStimulus(4'd6, 1'b0);
    goToPhase(2, 0);
    checkOutput("mid_pre", 4'b1011, 8'h24, 1'b1, 1'b0, 1'b1, 8'h24);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid_reset", 4'b1110, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF);
    tick(); tick(); tick();
    checkOutput("mid_hold", 4'b1110, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF);
    tick();
    checkOutput("mid_resume", 4'b1101, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF);

    begin
      int n = 0;
      while (scoreboard.size() > 0 && n < 10) begin
        @(negedge clk);
        n++;
      end
      if (scoreboard.size() > 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL drain: got %0d pending, expected 0", scoreboard.size());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
